// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: bus widths, arbiter state and owner encodings shared by the RAM arbiter.
// Revision: 1.0
`default_nettype none

package ram_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises IF and data-port accesses onto one single-ported RAM, one at a time.
// Revision: 1.0
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_en,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  input  logic              data_en,
  input  logic [SEL_W-1:0]  data_write_en,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              ram_en,
  output logic [SEL_W-1:0]  ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              stall_req
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] inst_hold_q, data_hold_q;

  logic in_resp, can_grant, data_elig, inst_elig, grant_data, grant_inst;

  // The port being answered in RESP still shows its finished request, so it is masked out.
  assign in_resp    = (state_q == ST_RESP);
  assign can_grant  = !rst && ((state_q == ST_IDLE) || in_resp);
  assign data_elig  = data_en && !(in_resp && owner_q == OWN_DATA);
  assign inst_elig  = inst_en && !(in_resp && owner_q == OWN_IF);
  assign grant_data = can_grant && data_elig;
  assign grant_inst = can_grant && inst_elig && !data_elig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      inst_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (in_resp && owner_q == OWN_IF)   inst_hold_q <= ram_read_data;
      if (in_resp && owner_q == OWN_DATA) data_hold_q <= ram_read_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    ram_en         = 1'b0;
    ram_write_en   = '0;
    ram_addr       = '0;
    ram_write_data = '0;

    if (grant_data) begin
      ram_en         = 1'b1;
      ram_write_en   = data_write_en;
      ram_addr       = data_addr;
      ram_write_data = data_wdata;
      owner_d        = OWN_DATA;
    end else if (grant_inst) begin
      ram_en   = 1'b1;
      ram_addr = inst_addr;
      owner_d  = OWN_IF;
    end

    if (grant_data || grant_inst) begin
      if (RAM_LATENCY == 1) begin
        state_d = ST_RESP;
      end else begin
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(RAM_LATENCY - 2);
      end
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (cnt_q == '0) state_d = ST_RESP;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A port that dropped its request gets no pulse; the response still retires.
  assign inst_ready = !rst && in_resp && (owner_q == OWN_IF)   && inst_en;
  assign data_ready = !rst && in_resp && (owner_q == OWN_DATA) && data_en;

  assign inst_rdata = (in_resp && owner_q == OWN_IF)   ? ram_read_data : inst_hold_q;
  assign data_rdata = (in_resp && owner_q == OWN_DATA) ? ram_read_data : data_hold_q;

  assign stall_req = (inst_en && !inst_ready) || (data_en && !data_ready);

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch port (IF) and the data port (the MEM stage RAM outputs).
- Serialises accesses with one outstanding transaction at a time.
- Returns read data and a per-port ready pulse.
- Raises a pipeline stall request while either port waits; sits between the core and the RAM wrapper.

Parameters:
- RAM_LATENCY, 1, cycles from RAM enable to valid ram_read_data; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- inst_en  input  1  IF read request; held until inst_ready.
- inst_addr  input  `ADDR_BUS  IF word address.
- inst_rdata  output  `DATA_BUS  fetched instruction, valid when inst_ready.
- inst_ready  output  1  one-cycle completion pulse for IF.
- data_en  input  1  data request (load or store); held until data_ready.
- data_write_en  input  `MEM_SEL_BUS  byte strobes; 0 means read.
- data_addr  input  `ADDR_BUS  word-aligned data address.
- data_wdata  input  `DATA_BUS  lane-aligned store data.
- data_rdata  output  `DATA_BUS  load data, valid when data_ready.
- data_ready  output  1  one-cycle completion pulse for the data port.
- ram_en  output  1  RAM access strobe; exactly one cycle per grant.
- ram_write_en  output  `MEM_SEL_BUS  RAM byte write enables.
- ram_addr  output  `ADDR_BUS  RAM address.
- ram_write_data  output  `DATA_BUS  RAM write data.
- ram_read_data  input  `DATA_BUS  RAM read data, RAM_LATENCY cycles after ram_en.
- stall_req  output  1  to pipeline control: (inst_en & ~inst_ready) | (data_en & ~data_ready).

Behaviour:
- States:
  - IDLE: no access outstanding.
  - BUSY: waiting; down-counter cnt holds the remaining wait cycles.
  - RESP: response cycle. owner records the granted port.
- Grant is evaluated in IDLE and RESP.
  - Data port has priority over IF.
  - In RESP, the port currently being answered is not eligible. Its request inputs still show the completed access this cycle.
  - This yields IF/data alternation under contention, so there is no starvation.
- On grant in cycle N:
  - RAM outputs are driven combinationally from the winner: ram_en=1; ram_write_en = data_write_en for data, 0 for IF.
  - owner is set to the winner.
  - If RAM_LATENCY=1, next state is RESP. Otherwise next state is BUSY with cnt=RAM_LATENCY-2.
- BUSY: cnt decrements each cycle; at cnt=0 the next state is RESP. No grants and no ram_en in BUSY.
- RESP (cycle N+RAM_LATENCY):
  - The owner's ready pulses high.
  - The owner's rdata equals ram_read_data combinationally; the value is also captured into that port's hold register.
  - Writes pulse ready identically; their rdata is don't-care.
  - If a grant occurs, next state is RESP or BUSY as above; otherwise IDLE.
- Outside RESP:
  - inst_rdata and data_rdata show their hold registers.
  - Ready outputs are 0.
  - ram_en, ram_write_en, ram_addr and ram_write_data are 0 when there is no grant.
- Back-to-back throughput with RAM_LATENCY=1: one access per cycle when both ports are active; two cycles per access for a single port.
- Reset values: state IDLE, cnt=0, owner=IF, both ready=0, both hold registers=0, all RAM outputs 0.
- Reset mid-operation: the outstanding access is dropped. No ready pulse follows. A write already issued to the RAM is not undone.
- Requests that drop before ready are ignored; the response still completes internally without a pulse to the departed port.
- Simultaneous IDLE requests: data wins, IF is granted in the data RESP cycle.
- Address alignment and lane steering are the requester's responsibility; the arbiter passes them through unchanged.

Decomposition:
- State encodings (IDLE/BUSY/RESP) and owner encodings go in `bus.v` or a shared arbiter defines header, next to the `ADDR_BUS`/`DATA_BUS`/`MEM_SEL_BUS` widths.
- No sub-module; the latency counter is inline.

Test Plan:
- Reset, then inst_en=1, inst_addr=0x0000_0100, RAM returns 0x2408_0005, RAM_LATENCY=1 -> ram_en in cycle 1 with ram_addr=0x100; inst_ready and inst_rdata=0x2408_0005 in cycle 2; stall_req=1 in cycle 1 only.
- inst_en and data_en (read 0x200) both asserted in IDLE -> data granted first; IF granted in the data RESP cycle; data_ready then inst_ready on consecutive cycles; ram_en high for 2 consecutive cycles.
- Store data_write_en=4'b0100, data_addr=0x300, data_wdata=0x00AB_0000 -> ram_write_en=4'b0100, ram_write_data=0x00AB_0000 for one cycle; data_ready next cycle.
- RAM_LATENCY=3, single IF read -> ram_en cycle 1, BUSY cycles 2-3, inst_ready cycle 4; no ram_en in cycles 2-3 even with data_en raised in cycle 2, which is granted in cycle 4.
- rst asserted in the BUSY cycle (RAM_LATENCY=3) -> no ready pulse afterwards; all outputs 0 the cycle after reset; fresh request completes normally.
- Both ports held continuously for 8 accesses -> strict alternation data, IF, data, IF, ...; hold registers keep the last values while ready is low.
